nbit_alu: RTL and testbench
===========================

Name: nbit_alu

Overview:
- Parameterised M-bit integer ALU with four operations selected by a 2-bit opcode: add, subtract, bitwise OR, bitwise XOR.
- Computes the result combinationally, then registers it with its status flags on the rising clock edge.
- Leaf datapath block, used wherever a small configurable arithmetic/logic unit is needed, including the single-bit (M=1) case.

Parameters:
- M, default 8: operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all registered outputs immediately.
- A  input  M  operand A, unsigned.
- B  input  M  operand B, unsigned.
- OPCODE  input  2  operation select (encoding in Behaviour).
- IN_VALID  input  1  operands/opcode valid this cycle.
- RESULT  output  M  registered operation result.
- CARRY  output  1  registered carry-out (ADD) or borrow (SUB); 0 for logic ops.
- ZERO  output  1  registered flag, 1 when RESULT == 0.
- OUT_VALID  output  1  registered; RESULT/CARRY/ZERO hold a new result this cycle.

Behaviour:
- Clocking: one clock (clk); reset is asynchronous and active-high (rst).
- Opcode encoding:
  - 2'b00 ADD: RESULT = (A + B) mod 2^M; CARRY = bit M of the (M+1)-bit sum.
  - 2'b10 SUB: RESULT = (A - B) mod 2^M (two's-complement wrap); CARRY = 1 when A < B unsigned (borrow), else 0.
  - 2'b01 OR: RESULT = A | B; CARRY = 0.
  - 2'b11 XOR: RESULT = A ^ B; CARRY = 0.
- Width rule: arithmetic is done at M+1 bits; RESULT is the low M bits, with no saturation.
- All four opcodes are defined, so there is no illegal-opcode case.
- Latency: exactly 1 cycle. Inputs sampled at rising edge k with IN_VALID=1 appear on the outputs after edge k, and OUT_VALID=1 for that one cycle.
- IN_VALID=0 at an edge: RESULT, CARRY and ZERO hold their previous values; OUT_VALID=0.
- Back-to-back IN_VALID=1 gives one result per cycle. There is no backpressure and no ready signal.
- ZERO is derived from the newly computed result and registered in the same edge as RESULT.
- Reset: while rst=1, RESULT=0, CARRY=0, ZERO=1, OUT_VALID=0, asserted immediately regardless of clk.
- Reset mid-operation: an operation sampled in the same cycle as reset is discarded.
- First valid edge after rst deasserts behaves normally.
- M=1:
  - ADD 1+1 gives RESULT=0, CARRY=1.
  - SUB 0-1 gives RESULT=1, CARRY=1.

Decomposition:
- Shared package nbit_alu_pkg:
  - 2-bit opcode typedef.
  - Constants OP_ADD=2'b00, OP_OR=2'b01, OP_SUB=2'b10, OP_XOR=2'b11.
- Sub-module nbit_alu_core: purely combinational, producing the M-bit result plus carry/borrow from A, B and OPCODE.
- Top nbit_alu holds the output register stage, ZERO generation and valid tracking.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> RESULT=0, CARRY=0, ZERO=1, OUT_VALID=0 immediately. Release, apply no valid input -> outputs unchanged.
- M=4 ADD with wrap: A=4'b1001, B=4'b1000, OPCODE=00, IN_VALID=1 -> next cycle RESULT=4'b0001, CARRY=1, ZERO=0, OUT_VALID=1.
- M=4 SUB:
  - A=3, B=5, OPCODE=10 -> RESULT=4'b1110, CARRY=1.
  - A=7, B=7 -> RESULT=0, ZERO=1, CARRY=0.
- M=4 logic ops:
  - A=4'b1100, B=4'b1010, OPCODE=01 -> RESULT=4'b1110, CARRY=0.
  - Same operands, OPCODE=11 -> RESULT=4'b0110.
- Throughput/hold: 3 consecutive valid ops then IN_VALID=0 -> 3 consecutive OUT_VALID pulses with matching results, then last result held with OUT_VALID=0.
- Randomised, M=1 and M=8: 100 random A/B/OPCODE -> RESULT matches the 1-cycle-delayed reference model for every op, including all four M=1 ADD/SUB corner cases.

Source files
------------

// File: rtl/nbit_alu_pkg.sv
// nbit_alu_pkg: opcode type and encodings shared by the ALU, its core and users.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nbit_alu_pkg;

    typedef logic [1:0] opcode_t;

    localparam opcode_t OP_ADD = 2'b00;
    localparam opcode_t OP_OR  = 2'b01;
    localparam opcode_t OP_SUB = 2'b10;
    localparam opcode_t OP_XOR = 2'b11;

endpackage : nbit_alu_pkg

// File: rtl/nbit_alu_if.sv
// nbit_alu_if: operand/opcode request and registered result/flag response of the ALU.
// Latency: n/a (wires only); response follows a valid request by one cycle.
// Backpressure: none; there is no ready, every valid request is accepted.
// Ports: A, B, OPCODE, IN_VALID (request); RESULT, CARRY, ZERO, OUT_VALID (response).
interface nbit_alu_if #(
    parameter int M = 8
);
    import nbit_alu_pkg::*;

    logic [M-1:0] A;
    logic [M-1:0] B;
    opcode_t      OPCODE;
    logic         IN_VALID;
    logic [M-1:0] RESULT;
    logic         CARRY;
    logic         ZERO;
    logic         OUT_VALID;

    // Requester side: drives operands, observes results.
    modport master (
        output A, B, OPCODE, IN_VALID,
        input  RESULT, CARRY, ZERO, OUT_VALID
    );

    // ALU side: consumes operands, drives results.
    modport slave (
        input  A, B, OPCODE, IN_VALID,
        output RESULT, CARRY, ZERO, OUT_VALID
    );

endinterface : nbit_alu_if

// File: rtl/nbit_alu_core.sv
// nbit_alu_core: combinational add/sub/or/xor on M-bit unsigned operands with carry/borrow.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: a, b, opcode in; result (M bits) and carry (carry-out for ADD, borrow for SUB) out.
module nbit_alu_core
    import nbit_alu_pkg::*;
#(
    parameter int M = 8
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    input  opcode_t      opcode,
    output logic [M-1:0] result,
    output logic         carry
);

    logic [M:0] sum;
    logic [M:0] diff;

    // Both arithmetic paths run one bit wider so the top bit falls out
    // as carry (add) or borrow (sub). For SUB, bit M of the widened
    // difference is set exactly when a < b.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (opcode)
            OP_ADD: begin
                result = sum[M-1:0];
                carry  = sum[M];
            end
            OP_SUB: begin
                result = diff[M-1:0];
                carry  = diff[M];
            end
            OP_OR: begin
                result = a | b;
            end
            OP_XOR: begin
                result = a ^ b;
            end
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule : nbit_alu_core

// File: rtl/nbit_alu.sv
// nbit_alu: M-bit ALU (add/sub/or/xor) with registered result, carry and zero flags.
// Latency: 1 cycle from a valid request edge to OUT_VALID; one result per cycle.
// Backpressure: none; outputs hold when IN_VALID is low, OUT_VALID pulses per result.
// Ports: clk, rst (async active-high); bus = nbit_alu_if slave (A, B, OPCODE, IN_VALID in;
//        RESULT, CARRY, ZERO, OUT_VALID out).
module nbit_alu
    import nbit_alu_pkg::*;
#(
    parameter int M = 8
) (
    input  logic          clk,
    input  logic          rst,
    nbit_alu_if.slave     bus
);

    logic [M-1:0] core_result;
    logic         core_carry;
    logic [M-1:0] result_q;
    logic         carry_q;
    logic         zero_q;
    logic         out_valid_q;

    nbit_alu_core #(
        .M (M)
    ) u_core (
        .a      (bus.A),
        .b      (bus.B),
        .opcode (bus.OPCODE),
        .result (core_result),
        .carry  (core_carry)
    );

    // Zero is taken from the freshly computed result so it lands in the
    // same edge as RESULT rather than lagging it by a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.IN_VALID;
            if (bus.IN_VALID) begin
                result_q <= core_result;
                carry_q  <= core_carry;
                zero_q   <= ~|core_result;
            end
        end
    end

    assign bus.RESULT    = result_q;
    assign bus.CARRY     = carry_q;
    assign bus.ZERO      = zero_q;
    assign bus.OUT_VALID = out_valid_q;

endmodule : nbit_alu

// File: tb/tb_nbit_alu.sv
// tb_nbit_alu: directed checks of nbit_alu at M=4, M=1 and M=8.
// Latency: expects results one cycle after each valid request.
// Backpressure: none exercised; requests are driven back-to-back or idle.
module tb_nbit_alu;
    import nbit_alu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    nbit_alu_if #(.M(4)) bus4 ();
    nbit_alu_if #(.M(1)) bus1 ();
    nbit_alu_if #(.M(8)) bus8 ();

    nbit_alu #(.M(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    nbit_alu #(.M(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    nbit_alu #(.M(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] res, input logic cy,
                        input logic zr, input logic ov);
        chk({tag, "_result"}, 64'(bus4.RESULT), 64'(res));
        chk({tag, "_carry"},  64'(bus4.CARRY),  64'(cy));
        chk({tag, "_zero"},   64'(bus4.ZERO),   64'(zr));
        chk({tag, "_valid"},  64'(bus4.OUT_VALID), 64'(ov));
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b,
                          input opcode_t op, input logic v);
        bus4.A = a;
        bus4.B = b;
        bus4.OPCODE = op;
        bus4.IN_VALID = v;
    endtask

    // Reference: {carry, result} for an M-bit operation, M <= 8.
    function automatic logic [8:0] ref_op(input int m, input opcode_t op,
                                          input logic [7:0] a, input logic [7:0] b);
        int unsigned ai;
        int unsigned bi;
        int unsigned mask;
        int unsigned r;
        logic        c;
        mask = (32'd1 << m) - 1;
        ai = 32'(a) & mask;
        bi = 32'(b) & mask;
        c = 1'b0;
        case (op)
            OP_ADD: begin r = ai + bi; c = (r > mask); end
            OP_SUB: begin r = ai - bi; c = (ai < bi); end
            OP_OR:  r = ai | bi;
            default: r = ai ^ bi;
        endcase
        r = r & mask;
        return {c, r[7:0]};
    endfunction

    logic [8:0] exp_v;
    logic [7:0] ra;
    logic [7:0] rb;
    opcode_t    rop;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive4(4'd0, 4'd0, OP_ADD, 1'b0);
        bus1.A = 1'b0; bus1.B = 1'b0; bus1.OPCODE = OP_ADD; bus1.IN_VALID = 1'b0;
        bus8.A = 8'd0; bus8.B = 8'd0; bus8.OPCODE = OP_ADD; bus8.IN_VALID = 1'b0;

        // Reset state.
        @(negedge clk);
        chk4("rst", 4'd0, 1'b0, 1'b1, 1'b0);
        chk("rst1_zero", 64'(bus1.ZERO), 64'd1);
        chk("rst8_result", 64'(bus8.RESULT), 64'd0);
        rst = 1'b0;

        // Idle after reset: outputs unchanged.
        @(negedge clk);
        chk4("idle", 4'd0, 1'b0, 1'b1, 1'b0);

        // ADD with wrap: 9 + 8 = 17 -> 1, carry.
        drive4(4'b1001, 4'b1000, OP_ADD, 1'b1);
        @(negedge clk);
        chk4("add_wrap", 4'b0001, 1'b1, 1'b0, 1'b1);

        // SUB with borrow: 3 - 5 = -2 -> 14.
        drive4(4'd3, 4'd5, OP_SUB, 1'b1);
        @(negedge clk);
        chk4("sub_borrow", 4'b1110, 1'b1, 1'b0, 1'b1);

        // SUB to zero.
        drive4(4'd7, 4'd7, OP_SUB, 1'b1);
        @(negedge clk);
        chk4("sub_zero", 4'd0, 1'b0, 1'b1, 1'b1);

        // OR and XOR.
        drive4(4'b1100, 4'b1010, OP_OR, 1'b1);
        @(negedge clk);
        chk4("or", 4'b1110, 1'b0, 1'b0, 1'b1);
        drive4(4'b1100, 4'b1010, OP_XOR, 1'b1);
        @(negedge clk);
        chk4("xor", 4'b0110, 1'b0, 1'b0, 1'b1);

        // Throughput: three back-to-back ops, then hold.
        drive4(4'd1, 4'd2, OP_ADD, 1'b1);
        @(negedge clk);
        chk4("tp0", 4'd3, 1'b0, 1'b0, 1'b1);
        drive4(4'd15, 4'd1, OP_SUB, 1'b1);
        @(negedge clk);
        chk4("tp1", 4'd14, 1'b0, 1'b0, 1'b1);
        drive4(4'd5, 4'd6, OP_XOR, 1'b1);
        @(negedge clk);
        chk4("tp2", 4'd3, 1'b0, 1'b0, 1'b1);
        drive4(4'd9, 4'd9, OP_ADD, 1'b0);
        @(negedge clk);
        chk4("hold0", 4'd3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk4("hold1", 4'd3, 1'b0, 1'b0, 1'b0);

        // Non-reset state, then async reset mid-cycle with an op pending.
        drive4(4'd3, 4'd4, OP_ADD, 1'b1);
        @(negedge clk);
        chk4("pre_rst", 4'd7, 1'b0, 1'b0, 1'b1);
        drive4(4'd1, 4'd1, OP_ADD, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk4("rst_async", 4'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk4("rst_discard", 4'd0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        drive4(4'd1, 4'd1, OP_ADD, 1'b0);
        @(negedge clk);
        chk4("rst_idle", 4'd0, 1'b0, 1'b1, 1'b0);
        drive4(4'd2, 4'd2, OP_ADD, 1'b1);
        @(negedge clk);
        chk4("post_rst", 4'd4, 1'b0, 1'b0, 1'b1);
        drive4(4'd0, 4'd0, OP_ADD, 1'b0);

        // M=1 corner cases, hand-computed.
        bus1.A = 1'b1; bus1.B = 1'b1; bus1.OPCODE = OP_ADD; bus1.IN_VALID = 1'b1;
        @(negedge clk);
        chk("m1_add11_result", 64'(bus1.RESULT), 64'd0);
        chk("m1_add11_carry",  64'(bus1.CARRY),  64'd1);
        chk("m1_add11_zero",   64'(bus1.ZERO),   64'd1);
        bus1.A = 1'b0; bus1.B = 1'b1; bus1.OPCODE = OP_SUB;
        @(negedge clk);
        chk("m1_sub01_result", 64'(bus1.RESULT), 64'd1);
        chk("m1_sub01_carry",  64'(bus1.CARRY),  64'd1);
        chk("m1_sub01_valid",  64'(bus1.OUT_VALID), 64'd1);

        // M=1 exhaustive sweep of every opcode and operand pair.
        for (int op = 0; op < 4; op++) begin
            for (int ab = 0; ab < 4; ab++) begin
                rop = opcode_t'(op);
                ra  = {7'd0, ab[1]};
                rb  = {7'd0, ab[0]};
                bus1.A = ra[0]; bus1.B = rb[0]; bus1.OPCODE = rop; bus1.IN_VALID = 1'b1;
                @(negedge clk);
                exp_v = ref_op(1, rop, ra, rb);
                chk("m1_sweep_result", 64'(bus1.RESULT), 64'(exp_v[0]));
                chk("m1_sweep_carry",  64'(bus1.CARRY),  64'(exp_v[8]));
                chk("m1_sweep_zero",   64'(bus1.ZERO),   64'(exp_v[0] == 1'b0));
            end
        end
        bus1.IN_VALID = 1'b0;

        // M=8 hand-computed: 200 + 100 = 300 -> 0x2C, carry.
        bus8.A = 8'd200; bus8.B = 8'd100; bus8.OPCODE = OP_ADD; bus8.IN_VALID = 1'b1;
        @(negedge clk);
        chk("m8_add_result", 64'(bus8.RESULT), 64'h2C);
        chk("m8_add_carry",  64'(bus8.CARRY),  64'd1);
        bus8.A = 8'd0; bus8.B = 8'd1; bus8.OPCODE = OP_SUB;
        @(negedge clk);
        chk("m8_sub_result", 64'(bus8.RESULT), 64'hFF);
        chk("m8_sub_carry",  64'(bus8.CARRY),  64'd1);

        // M=8 random operands against the reference.
        for (int i = 0; i < 100; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = opcode_t'($urandom_range(0, 3));
            bus8.A = ra; bus8.B = rb; bus8.OPCODE = rop; bus8.IN_VALID = 1'b1;
            @(negedge clk);
            exp_v = ref_op(8, rop, ra, rb);
            chk("m8_rand_result", 64'(bus8.RESULT), 64'(exp_v[7:0]));
            chk("m8_rand_carry",  64'(bus8.CARRY),  64'(exp_v[8]));
            chk("m8_rand_zero",   64'(bus8.ZERO),   64'(exp_v[7:0] == 8'd0));
            chk("m8_rand_valid",  64'(bus8.OUT_VALID), 64'd1);
        end
        bus8.IN_VALID = 1'b0;
        @(negedge clk);
        chk("m8_idle_valid", 64'(bus8.OUT_VALID), 64'd0);
        chk("m8_idle_hold",  64'(bus8.RESULT),    64'(exp_v[7:0]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_nbit_alu
